// File: rtl/shift_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : shift_pattern_ctrl
//  Brief    : Controller/sequencer for an 8-bit LED shift-pattern datapath.
//             Single clock domain; a prescaler produces a one-cycle step
//             enable. Runs Johnson / ring / reverse Johnson / ping-pong for
//             a latched step count (0 = run until stop).
//             Optional macro SHIFT_CTRL_PAUSE_EN adds a `pause` input and a
//             PAUSE state that freezes prescaler and pattern.
//  Revision : 1.0  initial release
// ============================================================================
module shift_pattern_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DIV_W   = 24,
    parameter int DIV_MAX = 12500000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [7:0]       steps,
`ifdef SHIFT_CTRL_PAUSE_EN
    input  logic             pause,
`endif
    output logic [WIDTH-1:0] SO,
    output logic             busy,
    output logic             done,
    output logic             step_tk
);

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(DIV_MAX - 1);
    localparam logic [DIV_W-1:0] c_div_one  = DIV_W'(1);
    localparam logic [WIDTH-1:0] c_seed_one = WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3
`ifdef SHIFT_CTRL_PAUSE_EN
        , ST_PAUSE = 3'd4
`endif
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_mode;
    logic [7:0]       r_remaining;
    logic [DIV_W-1:0] r_presc;
    logic [DIV_W-1:0] w_presc_nxt;
    logic             r_dir_left;
    logic             w_dir_nxt;
    logic [WIDTH-1:0] r_so;
    logic [WIDTH-1:0] w_so_adv;
    logic             r_busy;
    logic             r_done;
    logic             r_step_tk;
    logic             w_step;

    assign SO      = r_so;
    assign busy    = r_busy;
    assign done    = r_done;
    assign step_tk = r_step_tk;

    // A step happens in the RUN cycle where the prescaler sits at its last count.
    assign w_step = (r_state == ST_RUN) && (r_presc == c_div_last);

    // Next-state and next-prescaler decode; outputs are registered from these.
    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_presc_nxt = '0;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_presc_nxt = w_step ? '0 : (r_presc + c_div_one);
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_step && (r_remaining == 8'd1)) begin
                    w_state_nxt = ST_DONE;
                end
`ifdef SHIFT_CTRL_PAUSE_EN
                else if (pause) begin
                    w_state_nxt = ST_PAUSE;
                end
`endif
            end
`ifdef SHIFT_CTRL_PAUSE_EN
            ST_PAUSE: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (!pause) begin
                    w_state_nxt = ST_RUN;
                end
            end
`endif
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pattern advance: next value and ping-pong direction for the latched mode.
    always_comb begin
        w_so_adv  = r_so;
        w_dir_nxt = r_dir_left;
        case (r_mode)
            2'b00: w_so_adv = {r_so[WIDTH-2:0], ~r_so[WIDTH-1]};
            2'b01: w_so_adv = {r_so[WIDTH-2:0], r_so[WIDTH-1]};
            2'b10: w_so_adv = {~r_so[0], r_so[WIDTH-1:1]};
            default: begin
                if (r_dir_left) begin
                    w_so_adv = {r_so[WIDTH-2:0], 1'b0};
                    // Bit about to land on the MSB: bounce back next time.
                    if (r_so[WIDTH-2]) begin
                        w_dir_nxt = 1'b0;
                    end
                end else begin
                    w_so_adv = {1'b0, r_so[WIDTH-1:1]};
                    if (r_so[1]) begin
                        w_dir_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    // Controller state, datapath registers and registered status outputs.
    // step_tk is looked ahead from the next state/prescaler so that it is
    // high exactly in the cycle whose closing edge advances the pattern.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= ST_IDLE;
            r_mode      <= 2'b00;
            r_remaining <= 8'd0;
            r_presc     <= '0;
            r_dir_left  <= 1'b1;
            r_so        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_step_tk   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_busy    <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_RUN)
`ifdef SHIFT_CTRL_PAUSE_EN
                         || (w_state_nxt == ST_PAUSE)
`endif
                         ;
            r_done    <= (w_state_nxt == ST_DONE);
            r_step_tk <= (w_state_nxt == ST_RUN) && (w_presc_nxt == c_div_last);

            case (r_state)
                ST_IDLE: begin
                    if (w_state_nxt == ST_LOAD) begin
                        r_mode      <= mode;
                        r_remaining <= steps;
                    end
                end
                ST_LOAD: begin
                    r_so       <= r_mode[0] ? c_seed_one : '0;
                    r_dir_left <= 1'b1;
                end
                ST_RUN: begin
                    if (w_step) begin
                        r_so       <= w_so_adv;
                        r_dir_left <= w_dir_nxt;
                        if (r_remaining != 8'd0) begin
                            r_remaining <= r_remaining - 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_pattern_ctrl
//  Brief    : Directed self-checking bench for shift_pattern_ctrl
//             (WIDTH=8, DIV_MAX=4) with an expected-pattern scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_pattern_ctrl;

    localparam int WIDTH   = 8;
    localparam int DIV_W   = 8;
    localparam int DIV_MAX = 4;

    logic             clk;
    logic             clr;
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [7:0]       steps;
    logic             pause;
    logic [WIDTH-1:0] SO;
    logic             busy;
    logic             done;
    logic             step_tk;

    shift_pattern_ctrl #(
        .WIDTH   (WIDTH),
        .DIV_W   (DIV_W),
        .DIV_MAX (DIV_MAX)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .steps   (steps),
`ifdef SHIFT_CTRL_PAUSE_EN
        .pause   (pause),
`endif
        .SO      (SO),
        .busy    (busy),
        .done    (done),
        .step_tk (step_tk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               checks;
    int               errors;
    int               tkcnt;
    int               donecnt;
    logic             tk_prev;
    logic [WIDTH-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, pop the scoreboard when the
    // previous cycle carried a step pulse.
    task automatic tick();
        logic [WIDTH-1:0] e;
        @(negedge clk);
        if (tk_prev === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow observed=step expected=none");
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("so_step", 32'(SO), 32'(e));
            end
        end
        tk_prev = step_tk;
        if (step_tk === 1'b1) begin
            tkcnt++;
            chk("tk_busy", 32'(busy), 32'd1);
        end
        if (done === 1'b1) begin
            donecnt++;
            chk("done_busy", 32'(busy), 32'd0);
        end
    endtask

    task automatic run_until_done(input int maxc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (done !== 1'b1 && n < maxc);
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL done_timeout observed=%0d cycles expected=done", n);
        end
    endtask

    initial begin
        int               n;
        int               t0;
        int               d0;
        int               pos;
        logic [WIDTH-1:0] jtab [16];
        logic [WIDTH-1:0] v;

        jtab = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        checks = 0; errors = 0; tkcnt = 0; donecnt = 0; tk_prev = 1'b0;
        clr = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; steps = 8'd0; pause = 1'b0;

        // Reset state
        tick(); tick();
        clr = 1'b0;
        chk("rst_so", 32'(SO), 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tk", 32'(step_tk), 32'd0);

        // Johnson, 16 steps: step every 4 cycles, done 1+16*4 cycles after LOAD
        for (int i = 0; i < 16; i++) exp_q.push_back(jtab[i]);
        mode = 2'b00; steps = 8'd16; start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 65; k++) begin
            tick();
            chk("john_tk", 32'(step_tk), 32'(((k % 4) == 0) && (k <= 64)));
            chk("john_done", 32'(done), 32'(k == 65));
        end
        chk("john_end_so", 32'(SO), 32'h00);
        tick();
        chk("john_idle_busy", 32'(busy), 32'd0);
        chk("john_done_once", 32'(donecnt), 32'd1);
        chk("john_sb_empty", 32'(exp_q.size()), 32'd0);

        // Ping-pong, endless, stop on the 20th step cycle
        for (int i = 1; i <= 20; i++) begin
            pos = i % 14;
            if (pos > 7) pos = 14 - pos;
            v = '0;
            v[pos] = 1'b1;
            exp_q.push_back(v);
        end
        mode = 2'b11; steps = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        d0 = donecnt; t0 = tkcnt; n = 0;
        while ((tkcnt - t0) < 20 && n < 200) begin
            tick();
            n++;
        end
        chk("pp_reach20", 32'(tkcnt - t0), 32'd20);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("pp_stop_busy", 32'(busy), 32'd0);
        chk("pp_stop_so", 32'(SO), 32'h40);
        tick(); tick(); tick();
        chk("pp_hold_so", 32'(SO), 32'h40);
        chk("pp_no_done", 32'(donecnt - d0), 32'd0);
        chk("pp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Ring, 3 steps, start held high: mode/steps changes mid-run ignored
        exp_q.push_back(8'h02); exp_q.push_back(8'h04); exp_q.push_back(8'h08);
        mode = 2'b01; steps = 8'd3; start = 1'b1;
        tick();
        mode = 2'b10; steps = 8'd5;
        run_until_done(100, n);
        chk("ring_len", 32'(n), 32'd13);
        chk("ring_so", 32'(SO), 32'h08);
        mode = 2'b01; steps = 8'd3;
        tick();
        chk("ring_idle_busy", 32'(busy), 32'd0);
        chk("ring_idle_done", 32'(done), 32'd0);
        tick();
        chk("restart_busy", 32'(busy), 32'd1);
        tick();
        chk("restart_seed", 32'(SO), 32'h01);
        start = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("restart_stop", 32'(busy), 32'd0);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1;
        tick(); tick();
        chk("ss_busy", 32'(busy), 32'd0);
        chk("ss_so", 32'(SO), 32'h01);
        start = 1'b0; stop = 1'b0;

        // Reverse Johnson, 4 steps
        exp_q.push_back(8'h80); exp_q.push_back(8'hC0);
        exp_q.push_back(8'hE0); exp_q.push_back(8'hF0);
        mode = 2'b10; steps = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        run_until_done(100, n);
        chk("rj_len", 32'(n), 32'd17);
        chk("rj_so", 32'(SO), 32'hF0);
        tick();

`ifdef SHIFT_CTRL_PAUSE_EN
        // Pause 10 cycles with the prescaler mid-count
        exp_q.push_back(8'h02); exp_q.push_back(8'h04);
        mode = 2'b01; steps = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("pause_tk", 32'(step_tk), 32'd0);
            chk("pause_so", 32'(SO), 32'h02);
            chk("pause_busy", 32'(busy), 32'd1);
        end
        pause = 1'b0;
        tick();
        chk("resume_tk1", 32'(step_tk), 32'd0);
        tick();
        chk("resume_tk2", 32'(step_tk), 32'd1);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("pause_stop_busy", 32'(busy), 32'd0);
`endif

        // Synchronous clear mid-run, start asserted during clear
        exp_q.push_back(8'h01);
        mode = 2'b00; steps = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        clr = 1'b1; start = 1'b1;
        tick();
        chk("clr_so", 32'(SO), 32'h0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_done", 32'(done), 32'd0);
        chk("clr_tk", 32'(step_tk), 32'd0);
        tick();
        clr = 1'b0; start = 1'b0;
        tick();
        chk("post_clr_busy", 32'(busy), 32'd0);
        chk("post_clr_so", 32'(SO), 32'h0);
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
